// File: rtl/aftab_dawu_pkg.sv
// Shared definitions for the store-side byte serialiser: state encoding,
// size codes and the size-to-last-byte-index mapping.
package aftab_dawu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10,
        ST_EXC   = 2'b11
    } dawu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        logic [1:0] idx;
        case (sz)
            SZ_BYTE: idx = 2'd0;
            SZ_HALF: idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/aftab_dawu_controller.sv
// Sequencing FSM for the store unit: accepts a request, steps the byte
// counter on each memReady, and signals completion or rejection.
//   state | meaning
//   IDLE  | waiting for startDAWU
//   WRITE | presenting byte [counter], waiting for memReady
//   DONE  | one-cycle completion pulse
//   EXC   | one-cycle completion + exception pulse, no writes issued
module aftab_dawu_controller
    import aftab_dawu_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startDAWU,
    input  logic [1:0] nBytes,
    input  logic [1:0] addrLow,
    input  logic [1:0] sizeLatched,
    input  logic [1:0] cnt,
    input  logic       memReady,
    output logic       ldRegs,
    output logic       zeroCnt,
    output logic       incCnt,
    output logic       writeMem,
    output logic       completeDAWU,
    output logic       dawuExc
);

    dawu_state_e state_q, state_d;
    logic        reject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Rejection is decided from the raw request so no write cycle is ever spent on it
    always_comb begin
        reject = (nBytes == 2'b10);
        if (CHECK_ALIGN) begin
            if (nBytes == SZ_HALF && addrLow[0])       reject = 1'b1;
            if (nBytes == SZ_WORD && addrLow != 2'b00) reject = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ldRegs       = 1'b0;
        zeroCnt      = 1'b0;
        incCnt       = 1'b0;
        writeMem     = 1'b0;
        completeDAWU = 1'b0;
        dawuExc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (startDAWU) begin
                    ldRegs  = 1'b1;
                    zeroCnt = 1'b1;
                    state_d = reject ? ST_EXC : ST_WRITE;
                end
            end
            ST_WRITE: begin
                writeMem = 1'b1;
                if (memReady) begin
                    if (cnt == last_idx(sizeLatched)) state_d = ST_DONE;
                    else                               incCnt  = 1'b1;
                end
            end
            ST_DONE: begin
                completeDAWU = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                completeDAWU = 1'b1;
                dawuExc      = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/aftab_dawu.sv
// Data Adjustment Write Unit: serialises byte/half/word stores into
// byte-wide memory writes, least-significant byte first.
module aftab_dawu
    import aftab_dawu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startDAWU,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [31:0]       dataIn,
    input  logic [1:0]        nBytes,
    input  logic              memReady,
    output logic [ADDR_W-1:0] addrOut,
    output logic [7:0]        dataOut,
    output logic              writeMem,
    output logic              completeDAWU,
    output logic              dawuExc
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ld_regs, zero_cnt, inc_cnt;

    aftab_dawu_controller #(.CHECK_ALIGN(CHECK_ALIGN)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .startDAWU    (startDAWU),
        .nBytes       (nBytes),
        .addrLow      (addrIn[1:0]),
        .sizeLatched  (size_q),
        .cnt          (cnt_q),
        .memReady     (memReady),
        .ldRegs       (ld_regs),
        .zeroCnt      (zero_cnt),
        .incCnt       (inc_cnt),
        .writeMem     (writeMem),
        .completeDAWU (completeDAWU),
        .dawuExc      (dawuExc)
    );

    always_comb begin
        base_d = base_q;
        data_d = data_q;
        size_d = size_q;
        cnt_d  = cnt_q;
        if (ld_regs) begin
            base_d = addrIn;
            data_d = dataIn;
            size_d = nBytes;
        end
        if (zero_cnt)     cnt_d = 2'd0;
        else if (inc_cnt) cnt_d = cnt_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            data_q <= '0;
            size_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            data_q <= data_d;
            size_q <= size_d;
            cnt_q  <= cnt_d;
        end
    end

    // Address wraps modulo 2^ADDR_W; only reachable with alignment checks off
    assign addrOut = base_q + ADDR_W'(cnt_q);
    assign dataOut = data_q[{cnt_q, 3'b000} +: 8];

endmodule
